lcd_read_byte: RTL

LCD_READ_BYTE -- requirements
Module: lcd_read_byte

---
 rtl/lcd_read_byte.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/lcd_read_byte.sv
// Reads one byte from an HD44780-style LCD over a 4-bit bus as two E-strobed nibbles.
// Timing is set in CLK cycles; a single 12-bit counter times every phase.
module lcd_read_byte #(
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_PULSE = 12,
    parameter int unsigned T_GAP   = 50
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       doReadByte,
    input  logic       rsSel,
    input  logic [3:0] lcdData,
    output logic       lcdEnable,
    output logic       lcdRW,
    output logic       lcdRS,
    output logic       busRelease,
    output logic [7:0] readData,
    output logic       readByteReady,
    output logic       readByteDone
);

    typedef enum logic [2:0] {
        StReady     = 3'd0,
        StSetup     = 3'd1,
        StHighPulse = 3'd2,
        StGap       = 3'd3,
        StLowPulse  = 3'd4,
        StRecover   = 3'd5,
        StDone      = 3'd6
    } state_e;

    localparam logic [11:0] SetupLast = 12'(T_SETUP - 1);
    localparam logic [11:0] PulseLast = 12'(T_PULSE - 1);
    localparam logic [11:0] GapLast   = 12'(T_GAP - 1);

    state_e      state, stateNext;
    logic [11:0] cnt, cntNext;
    logic        rsReg;
    logic [7:0]  dataReg;
    logic        capHi, capLo, rsLoad;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= StReady;
            cnt     <= '0;
            rsReg   <= 1'b0;
            dataReg <= 8'h00;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            if (rsLoad) rsReg <= rsSel;
            if (capHi) dataReg[7:4] <= lcdData;
            if (capLo) dataReg[3:0] <= lcdData;
        end
    end

    // Counter runs up from zero in each timed state and is cleared on every state change.
    always_comb begin
        stateNext = state;
        cntNext   = cnt + 12'd1;
        rsLoad    = 1'b0;
        capHi     = 1'b0;
        capLo     = 1'b0;
        case (state)
            StReady: begin
                cntNext = '0;
                if (doReadByte) begin
                    stateNext = StSetup;
                    rsLoad    = 1'b1;
                end
            end
            StSetup: begin
                if (cnt == SetupLast) begin
                    stateNext = StHighPulse;
                    cntNext   = '0;
                end
            end
            StHighPulse: begin
                if (cnt == PulseLast) begin
                    stateNext = StGap;
                    cntNext   = '0;
                    capHi     = 1'b1;
                end
            end
            StGap: begin
                if (cnt == GapLast) begin
                    stateNext = StLowPulse;
                    cntNext   = '0;
                end
            end
            StLowPulse: begin
                if (cnt == PulseLast) begin
                    stateNext = StRecover;
                    cntNext   = '0;
                    capLo     = 1'b1;
                end
            end
            StRecover: begin
                if (cnt == SetupLast) begin
                    stateNext = StDone;
                    cntNext   = '0;
                end
            end
            StDone: begin
                stateNext = StReady;
                cntNext   = '0;
            end
            default: begin
                stateNext = StReady;
                cntNext   = '0;
            end
        endcase
    end

    always_comb begin
        lcdEnable     = 1'b0;
        lcdRW         = 1'b0;
        busRelease    = 1'b0;
        readByteReady = 1'b0;
        readByteDone  = 1'b0;
        lcdRS         = rsReg;
        case (state)
            StReady: begin
                readByteReady = 1'b1;
                lcdRS         = 1'b0;
            end
            StSetup, StGap, StRecover: begin
                lcdRW      = 1'b1;
                busRelease = 1'b1;
            end
            StHighPulse, StLowPulse: begin
                lcdEnable  = 1'b1;
                lcdRW      = 1'b1;
                busRelease = 1'b1;
            end
            StDone: readByteDone = 1'b1;
            default: lcdRS = 1'b0;
        endcase
    end

    assign readData = dataReg;

endmodule
